// File: rtl/lock_chamber_ctrl.sv
// Gondola lock chamber controller: water level, port states, occupancy and safety interlocks.
// Optional feature macro: LOCK_DOOR_DELAY_EN (ports take DOOR_CYCLES edges to travel).
module lock_chamber_ctrl #(
    parameter int LEVEL_W     = 14,
    parameter int OUTER_LEVEL = 100,
    parameter int INNER_LEVEL = 160,
    parameter int STEP        = 4,
    parameter int DOOR_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arrive,
    input  logic               depart,
    input  logic               outer_req,
    input  logic               inner_req,
    input  logic               raise,
    input  logic               lower,
    output logic [LEVEL_W-1:0] lock_level,
    output logic               outer_open,
    output logic               inner_open,
    output logic               occupied,
    output logic               busy,
    output logic               err
);

`ifdef LOCK_DOOR_DELAY_EN
    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DOOR} state_t;
    localparam int CNT_W = $clog2(DOOR_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DOOR_CYCLES - 1);
    logic [CNT_W-1:0] door_cnt, door_cnt_n;
    logic             door_outer, door_outer_n;
`else
    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
`endif

    if (INNER_LEVEL <= OUTER_LEVEL || STEP <= 0 || DOOR_CYCLES <= 0) begin : g_bad_params
        $error("lock_chamber_ctrl: invalid parameters");
    end

    localparam logic [LEVEL_W-1:0] OUTER_L = LEVEL_W'(OUTER_LEVEL);
    localparam logic [LEVEL_W-1:0] INNER_L = LEVEL_W'(INNER_LEVEL);
    localparam logic [LEVEL_W-1:0] STEP_L  = LEVEL_W'(STEP);
    localparam logic [LEVEL_W:0]   INNER_X = (LEVEL_W+1)'(INNER_LEVEL);
    localparam logic [LEVEL_W:0]   FLOOR_X = (LEVEL_W+1)'(OUTER_LEVEL + STEP);

    // Command protocol: each input is a one-cycle pulse with no ready/backpressure;
    // the controller either accepts it in IDLE (highest priority only) or flags err.
    state_t             state, state_n;
    logic [LEVEL_W-1:0] level_q, level_n;
    logic               outer_q, outer_n, inner_q, inner_n;
    logic               occ_q, occ_n, err_n;
    logic               tog_outer, tog_inner;
    logic [5:0]         cmds;
    logic [LEVEL_W:0]   fill_sum;
    logic               port_any;

    assign cmds     = {outer_req, inner_req, raise, lower, arrive, depart};
    assign fill_sum = {1'b0, level_q} + (LEVEL_W+1)'(STEP);
    assign port_any = outer_q | inner_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            level_q <= OUTER_L;
            outer_q <= 1'b0;
            inner_q <= 1'b0;
            occ_q   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            level_q <= level_n;
            outer_q <= outer_n;
            inner_q <= inner_n;
            occ_q   <= occ_n;
            err     <= err_n;
        end
    end

`ifdef LOCK_DOOR_DELAY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            door_cnt   <= '0;
            door_outer <= 1'b0;
        end else begin
            door_cnt   <= door_cnt_n;
            door_outer <= door_outer_n;
        end
    end
`endif

    always_comb begin
        state_n   = state;
        level_n   = level_q;
        outer_n   = outer_q;
        inner_n   = inner_q;
        occ_n     = occ_q;
        err_n     = 1'b0;
        tog_outer = 1'b0;
        tog_inner = 1'b0;
`ifdef LOCK_DOOR_DELAY_EN
        door_cnt_n   = door_cnt;
        door_outer_n = door_outer;
`endif
        case (state)
            IDLE: begin
                // Only the highest-priority pulse is a candidate; all others are rejected.
                if (outer_req) begin
                    err_n = |cmds[4:0];
                    if (outer_q || (!inner_q && level_q == OUTER_L)) tog_outer = 1'b1;
                    else err_n = 1'b1;
                end else if (inner_req) begin
                    err_n = |cmds[3:0];
                    if (inner_q || (!outer_q && level_q == INNER_L)) tog_inner = 1'b1;
                    else err_n = 1'b1;
                end else if (raise) begin
                    err_n = |cmds[2:0];
                    if (!port_any && level_q < INNER_L) state_n = FILL;
                    else err_n = 1'b1;
                end else if (lower) begin
                    err_n = |cmds[1:0];
                    if (!port_any && level_q > OUTER_L) state_n = DRAIN;
                    else err_n = 1'b1;
                end else if (arrive) begin
                    err_n = cmds[0];
                    if (!occ_q && port_any) occ_n = 1'b1;
                    else err_n = 1'b1;
                end else if (depart) begin
                    if (occ_q && port_any) occ_n = 1'b0;
                    else err_n = 1'b1;
                end
            end
            FILL: begin
                err_n = |cmds;
                if (fill_sum >= INNER_X) begin
                    level_n = INNER_L;
                    state_n = IDLE;
                end else begin
                    level_n = fill_sum[LEVEL_W-1:0];
                end
            end
            DRAIN: begin
                err_n = |cmds;
                // Compare before subtracting so the level can never underflow.
                if ({1'b0, level_q} <= FLOOR_X) begin
                    level_n = OUTER_L;
                    state_n = IDLE;
                end else begin
                    level_n = level_q - STEP_L;
                end
            end
`ifdef LOCK_DOOR_DELAY_EN
            DOOR: begin
                err_n = |cmds;
                if (door_cnt == CNT_LAST) begin
                    if (door_outer) outer_n = !outer_q;
                    else            inner_n = !inner_q;
                    state_n = IDLE;
                end else begin
                    door_cnt_n = door_cnt + 1'b1;
                end
            end
`endif
            default: state_n = IDLE;
        endcase

`ifdef LOCK_DOOR_DELAY_EN
        if (tog_outer || tog_inner) begin
            state_n      = DOOR;
            door_cnt_n   = '0;
            door_outer_n = tog_outer;
        end
`else
        if (tog_outer) outer_n = !outer_q;
        if (tog_inner) inner_n = !inner_q;
`endif
    end

    assign lock_level = level_q;
    assign outer_open = outer_q;
    assign inner_open = inner_q;
    assign occupied   = occ_q;
    assign busy       = (state != IDLE);

endmodule
